// File: rtl/byte_striping_pkg.sv
// Shared definitions for the byte striping / un-striping pair: default width,
// lane count and the slot encoding (which lane captures on the next edge).
package byte_striping_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NUM_LANES  = 2;

  typedef enum logic {
    SLOT_L0 = 1'b0,
    SLOT_L1 = 1'b1
  } slot_e;

  function automatic slot_e next_slot(input slot_e s);
    return (s == SLOT_L0) ? SLOT_L1 : SLOT_L0;
  endfunction

endpackage

// File: rtl/lane_hold_reg.sv
// Per-lane valid+data register: captures when enabled, zero-fills idle words.
// Optional saturating valid-word counter under BYTE_STRIPING_CNT_EN.
module lane_hold_reg
  import byte_striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef BYTE_STRIPING_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              capture,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [DATA_W-1:0] data
`ifdef BYTE_STRIPING_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt
`endif
);

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (capture) begin
      valid <= valid_in;
      data  <= valid_in ? data_in : '0;
    end
  end

`ifdef BYTE_STRIPING_CNT_EN
  // Counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      cnt <= '0;
    end else if (capture && valid_in && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/byte_striping.sv
// Splits one clk_2f word stream alternately onto two lanes, each word held two
// cycles, lane 1 staggered one cycle behind lane 0. Counters: BYTE_STRIPING_CNT_EN.
//
// state   | meaning
// SLOT_L0 | lane 0 captures on the next edge
// SLOT_L1 | lane 1 captures on the next edge
module byte_striping
  import byte_striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_0,
  output logic [DATA_W-1:0] lane_0,
  output logic              valid_1,
  output logic [DATA_W-1:0] lane_1,
  output logic              slot
`ifdef BYTE_STRIPING_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_0,
  output logic [CNT_W-1:0]  cnt_1
`endif
);

  slot_e slot_q, slot_d;
  logic  cap_0, cap_1;

  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("byte_striping: DATA_W and CNT_W must be at least 1");
  end

  // Slot schedule is free-running: idle cycles still consume their lane.
  always_ff @(posedge clk_2f) begin
    if (reset) slot_q <= SLOT_L0;
    else       slot_q <= slot_d;
  end

  always_comb begin
    slot_d = next_slot(slot_q);
    cap_0  = 1'b0;
    cap_1  = 1'b0;
    if (slot_q == SLOT_L0) cap_0 = 1'b1;
    else                   cap_1 = 1'b1;
  end

  assign slot = slot_q;

  lane_hold_reg #(
    .DATA_W (DATA_W)
`ifdef BYTE_STRIPING_CNT_EN
    ,
    .CNT_W  (CNT_W)
`endif
  ) u_lane_0 (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .capture  (cap_0),
    .valid_in (valid_in),
    .data_in  (data_in),
    .valid    (valid_0),
    .data     (lane_0)
`ifdef BYTE_STRIPING_CNT_EN
    ,
    .cnt      (cnt_0)
`endif
  );

  lane_hold_reg #(
    .DATA_W (DATA_W)
`ifdef BYTE_STRIPING_CNT_EN
    ,
    .CNT_W  (CNT_W)
`endif
  ) u_lane_1 (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .capture  (cap_1),
    .valid_in (valid_in),
    .data_in  (data_in),
    .valid    (valid_1),
    .data     (lane_1)
`ifdef BYTE_STRIPING_CNT_EN
    ,
    .cnt      (cnt_1)
`endif
  );

endmodule

// File: tb/tb_byte_striping.sv
// Bench for byte_striping: lane model indexed by cycle count since reset release,
// plus an un-striper emulation that rebuilds the word stream from the lanes.
module tb_byte_striping;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic              clk_2f = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              valid_0, valid_1, slot;
  logic [DATA_W-1:0] lane_0, lane_1;
`ifdef BYTE_STRIPING_CNT_EN
  logic [CNT_W-1:0]  cnt_0, cnt_1;
`endif

  byte_striping #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .valid_in (valid_in),
    .data_in  (data_in),
    .valid_0  (valid_0),
    .lane_0   (lane_0),
    .valid_1  (valid_1),
    .lane_1   (lane_1),
    .slot     (slot)
`ifdef BYTE_STRIPING_CNT_EN
    ,
    .cnt_0    (cnt_0),
    .cnt_1    (cnt_1)
`endif
  );

  always #5 clk_2f = ~clk_2f;

  int errors = 0;
  int checks = 0;

  int unsigned       idx = 0;
  logic              m_valid [2] = '{1'b0, 1'b0};
  logic [DATA_W-1:0] m_data  [2] = '{'0, '0};
  int                m_cnt   [2] = '{0, 0};
  logic [DATA_W-1:0] sent_q[$];
  logic [DATA_W-1:0] recv_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d);
    int ln;
    ln       = 0;
    reset    = r;
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f);
    if (r) begin
      idx     = 0;
      m_valid = '{1'b0, 1'b0};
      m_data  = '{'0, '0};
      m_cnt   = '{0, 0};
      sent_q.delete();
      recv_q.delete();
    end else begin
      ln          = int'(idx % 2);
      m_valid[ln] = v;
      m_data[ln]  = v ? d : '0;
      if (v) begin
        sent_q.push_back(d);
        if (m_cnt[ln] < (1 << CNT_W) - 1) m_cnt[ln]++;
      end
      idx++;
    end
    #1;
    chk("valid_0", 64'(valid_0), 64'(m_valid[0]));
    chk("lane_0",  64'(lane_0),  64'(m_data[0]));
    chk("valid_1", 64'(valid_1), 64'(m_valid[1]));
    chk("lane_1",  64'(lane_1),  64'(m_data[1]));
    chk("slot",    64'(slot),    64'(idx % 2));
`ifdef BYTE_STRIPING_CNT_EN
    chk("cnt_0",   64'(cnt_0),   64'(m_cnt[0]));
    chk("cnt_1",   64'(cnt_1),   64'(m_cnt[1]));
`endif
    // Un-striper emulation: take the word from the lane that just captured.
    if (!r) begin
      if (ln == 0 && valid_0) recv_q.push_back(lane_0);
      if (ln == 1 && valid_1) recv_q.push_back(lane_1);
    end
  endtask

  task automatic check_loopback(input string name);
    int n;
    chk({name, "_count"}, 64'(recv_q.size()), 64'(sent_q.size()));
    n = (recv_q.size() < sent_q.size()) ? recv_q.size() : sent_q.size();
    for (int i = 0; i < n; i++) chk({name, "_word"}, 64'(recv_q[i]), 64'(sent_q[i]));
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;

    // Reset with live-looking input
    step(1'b1, 1'b1, 32'hFFFFFFFF);
    step(1'b1, 1'b1, 32'hFFFFFFFF);
    chk("rst_lane_0", 64'(lane_0), 64'h0);
    chk("rst_valid_0", 64'(valid_0), 64'h0);
    chk("rst_slot", 64'(slot), 64'h0);

    // Continuous stream
    step(1'b0, 1'b1, 32'hFFFFFFFF);
    chk("e1_lane_0", 64'(lane_0), 64'hFFFFFFFF);
    step(1'b0, 1'b1, 32'hEEEEEEEE);
    chk("e2_lane_0", 64'(lane_0), 64'hFFFFFFFF);
    chk("e2_lane_1", 64'(lane_1), 64'hEEEEEEEE);
    step(1'b0, 1'b1, 32'hDDDDDDDD);
    chk("e3_lane_0", 64'(lane_0), 64'hDDDDDDDD);
    chk("e3_lane_1", 64'(lane_1), 64'hEEEEEEEE);
    step(1'b0, 1'b1, 32'hCCCCCCCC);
    chk("e4_lane_0", 64'(lane_0), 64'hDDDDDDDD);
    chk("e4_lane_1", 64'(lane_1), 64'hCCCCCCCC);
    chk("e4_valids", 64'({valid_0, valid_1}), 64'h3);

    // Idle gap in a lane 0 slot
    step(1'b0, 1'b0, 32'h11111111);
    chk("gap_valid_0", 64'(valid_0), 64'h0);
    chk("gap_lane_0", 64'(lane_0), 64'h0);
    chk("gap_lane_1", 64'(lane_1), 64'hCCCCCCCC);
    step(1'b0, 1'b1, 32'hBBBBBBBB);
    chk("gap2_lane_0", 64'(lane_0), 64'h0);
    check_loopback("stream");

    // Reset mid-stream while slot=1 and lane_0 holds AAAAAAAA
    step(1'b0, 1'b1, 32'hAAAAAAAA);
    chk("pre_rst_slot", 64'(slot), 64'h1);
    step(1'b1, 1'b1, 32'h55555555);
    chk("mid_rst_lane_0", 64'(lane_0), 64'h0);
    chk("mid_rst_lane_1", 64'(lane_1), 64'h0);
    step(1'b0, 1'b1, 32'h99999999);
    chk("post_rst_lane_0", 64'(lane_0), 64'h99999999);
    chk("post_rst_valid_1", 64'(valid_1), 64'h0);

    // Loopback sequence with a gap
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 32'h00000003);
    step(1'b0, 1'b1, 32'h00000004);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h00000007);
    step(1'b0, 1'b1, 32'h00000008);
    step(1'b0, 1'b1, 32'h22222222);
    step(1'b0, 1'b0, 32'h0);
    chk("lb_count_lit", 64'(recv_q.size()), 64'd5);
    check_loopback("loopback");

`ifdef BYTE_STRIPING_CNT_EN
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'(i + 1));
    chk("cnt5_cnt_0", 64'(cnt_0), 64'd3);
    chk("cnt5_cnt_1", 64'(cnt_1), 64'd2);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'(i + 100));
    chk("sat_cnt_0", 64'(cnt_0), 64'd3);
    chk("sat_cnt_1", 64'(cnt_1), 64'd3);
`endif

    // Randomized traffic with occasional resets
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), DATA_W'($urandom));
    end
    step(1'b0, 1'b0, '0);
    check_loopback("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_striping.md
Name: byte_striping

Overview:
- Transmit-side counterpart of the byte un-striping block.
- Takes one word stream at clk_2f rate (one word per cycle) and distributes consecutive cycles alternately onto lane 0 and lane 1.
- Each lane word is held for two clk_2f cycles (clk_f rate), and lane 1 is staggered one cycle behind lane 0.
- Sits between the serializer-side word source and the two per-lane paths; its outputs feed byte_un_striping directly in loopback.

Parameters:
- DATA_W, 32, width of input word and of each lane word.
- CNT_W, 16, width of per-lane valid-word counters (used only with the optional feature).

Ports:
- clk_2f  input  1  double-rate clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in carries a word this cycle.
- data_in  input  DATA_W  input word.
- valid_0  output  1  lane 0 word valid.
- lane_0  output  DATA_W  lane 0 word.
- valid_1  output  1  lane 1 word valid.
- lane_1  output  DATA_W  lane 1 word.
- slot  output  1  lane that captures on the next edge (0 = lane 0, 1 = lane 1).

Behaviour:
- Internal 1-bit slot register; toggles on every non-reset edge, unconditionally, regardless of valid_in. The slot schedule is fixed, not data-driven.
- Edge with reset=1:
  - slot<=0, valid_0<=0, lane_0<=0, valid_1<=0, lane_1<=0.
  - These are the reset values of all outputs. Inputs on that edge are ignored.
- Edge with reset=0 and slot=0:
  - valid_0<=valid_in.
  - lane_0<=data_in if valid_in, else 0 (idle lanes carry all-zero data).
  - Lane 1 registers hold. slot<=1.
- Edge with reset=0 and slot=1: same as above with lane 1 / lane 0 swapped; slot<=0.
- Latency: 1 clk_2f cycle from input to lane register.
- Each lane register changes at most every 2 cycles, so each word is held exactly 2 cycles. Lane 1 updates on the edges between lane 0 updates (one-cycle stagger).
- The first cycle after reset deasserts always goes to lane 0. Word order is input cycle N -> lane (N mod 2), counted from reset release.
- Reset mid-stream (any slot): the next edge clears everything; any word presented on that edge is dropped.
- Invalid input cycles consume their slot. No re-alignment, no backpressure; the source must present a word every cycle it has one.
- No arithmetic beyond the slot toggle (and counters, if enabled).

Optional Feature:
- Macro: BYTE_STRIPING_CNT_EN.
- When defined:
  - Adds outputs cnt_0 and cnt_1 (CNT_W each).
  - Each counts valid words captured into its lane.
  - Increments on the same edge the lane register captures with valid_in=1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared to 0 by reset.
- When undefined: ports and counter logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package byte_striping_pkg:
  - DATA_W_DEF=32, NUM_LANES=2.
  - Slot encoding constants SLOT_L0=1'b0 and SLOT_L1=1'b1.
  - Shared with byte_un_striping.
- One natural sub-module, lane_hold_reg, instantiated twice. It is a capture-enabled valid+data register with synchronous clear, zero-fill on invalid, and the optional saturating counter.
- Top level holds the slot register and the two instances.

Test Plan:
- Reset: hold reset=1 for 2 edges with valid_in=1, data_in=FFFFFFFF -> all outputs 0, slot=0.
- Continuous stream: after release, drive FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC on consecutive cycles (valid=1) -> required outputs:
  - lane_0=FFFFFFFF on edges 1-2.
  - lane_1=EEEEEEEE on edges 2-3.
  - lane_0=DDDDDDDD on edges 3-4.
  - lane_1=CCCCCCCC on edges 4-5.
  - valid_0 and valid_1 are 1 throughout.
- Idle gap: valid_in=0 with data_in=11111111 in a lane 0 slot -> valid_0=0 and lane_0=00000000 for 2 cycles; lane 1 unaffected.
- Reset mid-stream: assert reset while slot=1 with lane_0=AAAAAAAA held -> next edge all outputs 0. After release, 99999999 lands on lane_0, not lane_1.
- Loopback: feed byte_un_striping with these outputs. Send 00000003, 00000004, gap, 00000007, 00000008, 22222222 -> the un-striper reproduces the same valid word sequence in order.
- With BYTE_STRIPING_CNT_EN and CNT_W=2:
  - 5 consecutive valid words -> cnt_0=3, cnt_1=2.
  - 8 more valid words -> cnt_0=3 and cnt_1=3 (saturated).
